// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_EXT  = 2'b10
    } owner_e;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_MAX_WAIT  = 4;
    localparam int unsigned DEF_LOCK_IDLE = 8;

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating event counter built as a down-counter from MAX with terminal-count compare.
// will_max flags the increment that makes the count reach MAX on the next edge.
module dmem_port_arbiter_sat_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max,
    output logic will_max
);

    localparam int unsigned   CW   = (MAX < 2) ? 1 : $clog2(MAX + 1);
    localparam logic [CW-1:0] LOAD = CW'(MAX);

    logic [CW-1:0] rem_q;
    logic [CW-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (clr) begin
            rem_d = LOAD;
        end else if (inc && (rem_q != '0)) begin
            rem_d = rem_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= LOAD;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign at_max   = (rem_q == '0);
    assign will_max = inc && !clr && (rem_q == CW'(1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single Data_Memory port between the MIPS core (default priority) and an
// external master with starvation-bounded access and optional locked bursts.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
    parameter int unsigned LOCK_IDLE = DEF_LOCK_IDLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [WIDTH-1:0]  ext_wdata,
    output logic              ext_ready,
    output logic [WIDTH-1:0]  ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [1:0]        owner
);

    owner_e            own_raw;
    logic              ext_accept;
    logic              wait_at_max;
    logic              wait_near_unused;
    logic              idle_at_max;
    logic              idle_will_max;
    logic              lock_q;
    logic              lock_d;
    logic              ext_rvalid_q;
    logic              ext_rvalid_d;
    logic [WIDTH-1:0]  ext_rdata_q;
    logic [WIDTH-1:0]  ext_rdata_d;

    // State-update path deliberately ignores rst; reset only gates the visible outputs.
    always_comb begin
        own_raw = OWN_NONE;
        if (lock_q) begin
            own_raw = OWN_EXT;
        end else if (ext_valid && wait_at_max) begin
            own_raw = OWN_EXT;
        end else if (cpu_req) begin
            own_raw = OWN_CPU;
        end else if (ext_valid) begin
            own_raw = OWN_EXT;
        end
    end

    assign ext_accept = (own_raw == OWN_EXT) && ext_valid;

    dmem_port_arbiter_sat_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (ext_valid && !ext_accept),
        .clr      (ext_accept),
        .at_max   (wait_at_max),
        .will_max (wait_near_unused)
    );

    dmem_port_arbiter_sat_counter #(.MAX(LOCK_IDLE)) u_idle_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (lock_q && !ext_valid),
        .clr      (!lock_q || ext_valid),
        .at_max   (idle_at_max),
        .will_max (idle_will_max)
    );

    // Unlock on the edge where the idle count reaches LOCK_IDLE, so the cpu owns the next cycle.
    always_comb begin
        lock_d = lock_q;
        if (ext_accept) begin
            lock_d = ext_lock;
        end else if (idle_will_max || idle_at_max) begin
            lock_d = 1'b0;
        end
    end

    always_comb begin
        ext_rvalid_d = ext_accept && !ext_we;
        ext_rdata_d  = ext_rvalid_d ? mem_rdata : ext_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= 1'b0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            lock_q       <= lock_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    always_comb begin
        owner     = OWN_NONE;
        cpu_stall = 1'b0;
        ext_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            owner     = own_raw;
            cpu_stall = cpu_req && (own_raw != OWN_CPU);
            ext_ready = ext_accept;
            if (own_raw == OWN_EXT) begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_we    = ext_we && ext_valid;
            end else begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = (own_raw == OWN_CPU) && cpu_req && cpu_we;
            end
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = ext_rdata_q;
    assign ext_rvalid = ext_rvalid_q;

endmodule
